// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry output hold.
// Misaligned PCs skip memory and present an exception-flagged zero instruction.
module ifetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc,
    output logic        pc_write,
    input  logic        flush,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        out_exc
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [63:0] req_pc_q, req_pc_d;
    logic [31:0] inst_q, inst_d;
    logic        exc_q, exc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
            inst_q   <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            inst_q   <= inst_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        inst_d     = inst_q;
        exc_d      = exc_q;
        ireq_valid = 1'b0;
        out_valid  = 1'b0;
        pc_write   = flush;

        unique case (state_q)
            IDLE: begin
                if (!flush) begin
                    req_pc_d = pc;
                    if (pc[1:0] == 2'b00) begin
                        exc_d   = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = '0;
                        exc_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            REQ: begin
                ireq_valid = 1'b1;
                if (flush) begin
                    // A redirect with the response still in flight must wait it out.
                    state_d = iresp_ok ? IDLE : DRAIN;
                end else if (iresp_ok) begin
                    inst_d  = iresp_data;
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                ireq_valid = 1'b1;
                if (iresp_ok) state_d = IDLE;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    pc_write = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset masks all strobes, including a flush arriving during reset.
        if (reset) begin
            ireq_valid = 1'b0;
            out_valid  = 1'b0;
            pc_write   = 1'b0;
        end
    end

    assign ireq_addr = req_pc_q;
    assign out_inst  = inst_q;
    assign out_pc    = req_pc_q;
    assign out_exc   = exc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed scenarios followed by randomized traffic checked against a
// PC-stream scoreboard (bench plays the PC register and the instruction memory).
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic        pc_write;
    logic        flush;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_exc;

    always #5 clk = ~clk;

    ifetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_write   (pc_write),
        .flush      (flush),
        .ireq_valid (ireq_valid),
        .ireq_addr  (ireq_addr),
        .iresp_ok   (iresp_ok),
        .iresp_data (iresp_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_exc    (out_exc)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   fires  = 0;
    logic mon_en = 1'b0;
    exp_t sb[$];

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F13;
    endfunction

    // Architectural expectation for whatever PC the PC register currently holds.
    function automatic exp_t mk(input logic [63:0] p);
        exp_t e;
        e.pc   = p;
        e.exc  = (p[1:0] != 2'b00);
        e.inst = e.exc ? 32'd0 : mem(p);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol checks every cycle plus scoreboard pop on each handshake.
    logic        hold_prev = 1'b0;
    logic        flush_prev = 1'b0;
    logic [31:0] inst_prev;
    logic [63:0] pc_prev;
    logic        exc_prev;
    exp_t        got;

    always @(negedge clk) begin
        if (mon_en) begin
            #2;
            chkb("pc_write", pc_write, flush | (out_valid & out_ready));
            if (ireq_valid && out_valid) chkb("req_and_out_overlap", 1'b1, 1'b0);
            if (flush_prev) chkb("out_valid_after_flush", out_valid, 1'b0);
            if (hold_prev) begin
                chkb("hold_valid", out_valid, 1'b1);
                chk("hold_inst", {32'd0, out_inst}, {32'd0, inst_prev});
                chk("hold_pc", out_pc, pc_prev);
                chkb("hold_exc", out_exc, exc_prev);
            end
            if (out_valid && out_ready && !flush) begin
                fires++;
                if (sb.size() == 0) begin
                    chkb("sb_empty_on_handshake", 1'b1, 1'b0);
                end else begin
                    got = sb.pop_front();
                    chk("sb_out_pc", out_pc, got.pc);
                    chk("sb_out_inst", {32'd0, out_inst}, {32'd0, got.inst});
                    chkb("sb_out_exc", out_exc, got.exc);
                end
            end
            hold_prev  = out_valid & !out_ready & !flush;
            flush_prev = flush;
            inst_prev  = out_inst;
            pc_prev    = out_pc;
            exc_prev   = out_exc;
        end
    end

    logic        pending;
    logic [63:0] raddr;
    int          dly;
    logic        prev_pw, prev_fl;
    logic [63:0] prev_tgt, tgt;
    logic [1:0]  lo;

    initial begin
        reset = 1'b1; pc = 64'h8000_0000; flush = 1'b0;
        iresp_ok = 1'b0; iresp_data = '0; out_ready = 1'b0;

        // Reset: strobes low even with flush high; registers cleared.
        @(negedge clk); flush = 1'b1; #1;
        chkb("rst_pc_write", pc_write, 1'b0);
        chkb("rst_ireq_valid", ireq_valid, 1'b0);
        chkb("rst_out_valid", out_valid, 1'b0);
        @(negedge clk); flush = 1'b0; #1;
        chk("rst_req_pc", ireq_addr, 64'd0);
        chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
        chkb("rst_out_exc", out_exc, 1'b0);

        // Basic fetch: response one cycle after request, accepted immediately.
        @(negedge clk); reset = 1'b0; #1;
        chkb("idle_no_req", ireq_valid, 1'b0);
        @(negedge clk); #1;
        chkb("req_valid", ireq_valid, 1'b1);
        chk("req_addr", ireq_addr, 64'h8000_0000);
        @(negedge clk); iresp_ok = 1'b1; iresp_data = 32'h0000_0013; #1;
        chk("req_addr_stable", ireq_addr, 64'h8000_0000);
        @(negedge clk); iresp_ok = 1'b0; out_ready = 1'b1; #1;
        chkb("fetch_out_valid", out_valid, 1'b1);
        chk("fetch_out_inst", {32'd0, out_inst}, 64'h13);
        chk("fetch_out_pc", out_pc, 64'h8000_0000);
        chkb("fetch_out_exc", out_exc, 1'b0);
        chkb("fetch_pc_write", pc_write, 1'b1);

        // Misaligned PC: no request, exception entry held 5 cycles then accepted.
        @(negedge clk); pc = 64'h8000_0002; out_ready = 1'b0; #1;
        chkb("mis_idle_no_req", ireq_valid, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chkb("mis_no_req", ireq_valid, 1'b0);
            chkb("mis_out_valid", out_valid, 1'b1);
            chkb("mis_out_exc", out_exc, 1'b1);
            chk("mis_out_inst", {32'd0, out_inst}, 64'd0);
            chk("mis_out_pc", out_pc, 64'h8000_0002);
            chkb("stall_pc_write", pc_write, 1'b0);
        end
        @(negedge clk); out_ready = 1'b1; #1;
        chkb("stall_release_valid", out_valid, 1'b1);
        chkb("stall_release_pc_write", pc_write, 1'b1);

        // Flush in REQ, response three cycles later: drain old request.
        @(negedge clk); out_ready = 1'b0; pc = 64'h8000_0100; #1;
        chkb("after_hs_idle", out_valid, 1'b0);
        @(negedge clk); flush = 1'b1; #1;
        chk("drain_req_addr", ireq_addr, 64'h8000_0100);
        chkb("flush_pc_write", pc_write, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin flush = 1'b0; pc = 64'h8000_0200; end
            iresp_ok = (k == 2); iresp_data = 32'hDEAD_BEEF; #1;
            chkb("drain_valid", ireq_valid, 1'b1);
            chk("drain_addr_old", ireq_addr, 64'h8000_0100);
            chkb("drain_no_out", out_valid, 1'b0);
        end
        @(negedge clk); iresp_ok = 1'b0; #1;
        chkb("drain_done_idle", ireq_valid, 1'b0);
        chkb("drain_done_no_out", out_valid, 1'b0);

        // Flush with same-cycle response: straight to IDLE, new PC fetched next.
        @(negedge clk); flush = 1'b1; iresp_ok = 1'b1; iresp_data = 32'h0BAD_0BAD; #1;
        chk("new_pc_latched", ireq_addr, 64'h8000_0200);
        chkb("flush_ok_pc_write", pc_write, 1'b1);
        @(negedge clk); flush = 1'b0; iresp_ok = 1'b0; pc = 64'h8000_0300; #1;
        chkb("flush_ok_no_out", out_valid, 1'b0);
        chkb("flush_ok_idle", ireq_valid, 1'b0);

        // Reset during DRAIN, then a stray response in IDLE.
        @(negedge clk); flush = 1'b1; #1;
        chk("req_addr_3", ireq_addr, 64'h8000_0300);
        @(negedge clk); flush = 1'b0; #1;
        chkb("in_drain", ireq_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0; iresp_ok = 1'b1; iresp_data = 32'h0BAD_0002;
        pc = 64'h8000_0400; #1;
        chkb("rst_drain_no_req", ireq_valid, 1'b0);
        chkb("rst_drain_no_out", out_valid, 1'b0);
        chk("rst_drain_req_pc", ireq_addr, 64'd0);
        @(negedge clk); iresp_ok = 1'b1; iresp_data = 32'h0000_0055; #1;
        chkb("post_rst_req", ireq_valid, 1'b1);
        chk("post_rst_addr", ireq_addr, 64'h8000_0400);
        chkb("stray_ignored", out_valid, 1'b0);
        @(negedge clk); iresp_ok = 1'b0; out_ready = 1'b1; #1;
        chkb("post_rst_out_valid", out_valid, 1'b1);
        chk("post_rst_out_inst", {32'd0, out_inst}, 64'h55);

        // Randomized phase.
        @(negedge clk); reset = 1'b1; out_ready = 1'b0; pc = 64'h8000_1000;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        sb.delete(); sb.push_back(mk(pc));
        pending = 1'b0; dly = 0; raddr = '0;
        prev_pw = 1'b0; prev_fl = 1'b0; prev_tgt = '0;
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) @(negedge clk);
            // PC register: load redirect target on flush, else advance on handshake.
            if (prev_fl) begin
                pc = prev_tgt;
                sb.delete();
                sb.push_back(mk(pc));
            end else if (prev_pw) begin
                pc = pc + 64'd4;
                sb.push_back(mk(pc));
            end
            // Memory: one request at a time, random latency, stray strobes when idle.
            if (ireq_valid) begin
                if (!pending) begin
                    pending = 1'b1; raddr = ireq_addr; dly = $urandom_range(0, 3);
                end else begin
                    chk("ireq_addr_stable", ireq_addr, raddr);
                end
                if (dly == 0) begin
                    iresp_ok = 1'b1; iresp_data = mem(raddr); pending = 1'b0;
                end else begin
                    dly--; iresp_ok = 1'b0; iresp_data = $urandom;
                end
            end else begin
                if (pending) chk("req_dropped", 64'd0, raddr);
                pending = 1'b0;
                iresp_ok = ($urandom_range(0, 7) == 0);
                iresp_data = $urandom;
            end
            flush = ($urandom_range(0, 9) == 0);
            lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            tgt = {32'h0000_0001, 16'h8000, 14'($urandom), lo};
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            prev_pw = pc_write; prev_fl = flush; prev_tgt = tgt;
        end
        @(negedge clk); mon_en = 1'b0; flush = 1'b0; iresp_ok = 1'b0;
        chkb("throughput", fires >= 100, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
